// File: rtl/tea_arbiter_if.sv
// Bundle of the requester, result and core-side handshakes around tea_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface tea_arbiter_if;
    logic         s0_valid;
    logic         s0_ready;
    logic [63:0]  s0_data;
    logic [127:0] s0_key;
    logic         s1_valid;
    logic         s1_ready;
    logic [63:0]  s1_data;
    logic [127:0] s1_key;
    logic         m0_valid;
    logic         m0_ready;
    logic [63:0]  m0_data;
    logic         m1_valid;
    logic         m1_ready;
    logic [63:0]  m1_data;
    logic         core_req_valid;
    logic         core_req_ready;
    logic [63:0]  core_req_data;
    logic [127:0] core_req_key;
    logic         core_rsp_valid;
    logic         core_rsp_ready;
    logic [63:0]  core_rsp_data;
    logic         busy;
    logic         grant;
    logic         timeout;

    modport slave (
        input  s0_valid, s0_data, s0_key, s1_valid, s1_data, s1_key,
        input  m0_ready, m1_ready, core_req_ready, core_rsp_valid, core_rsp_data,
        output s0_ready, s1_ready, m0_valid, m0_data, m1_valid, m1_data,
        output core_req_valid, core_req_data, core_req_key, core_rsp_ready,
        output busy, grant, timeout
    );

    modport master (
        output s0_valid, s0_data, s0_key, s1_valid, s1_data, s1_key,
        output m0_ready, m1_ready, core_req_ready, core_rsp_valid, core_rsp_data,
        input  s0_ready, s1_ready, m0_valid, m0_data, m1_valid, m1_data,
        input  core_req_valid, core_req_data, core_req_key, core_rsp_ready,
        input  busy, grant, timeout
    );
endinterface

// File: rtl/tea_arbiter.sv
// Shares one non-pipelined TEA core between two requesters: one job in flight,
// round-robin on ties, optional abort of a job whose result never arrives.
module tea_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_s0_valid,
    output logic         o_s0_ready,
    input  logic [63:0]  i_s0_data,
    input  logic [127:0] i_s0_key,
    input  logic         i_s1_valid,
    output logic         o_s1_ready,
    input  logic [63:0]  i_s1_data,
    input  logic [127:0] i_s1_key,
    output logic         o_m0_valid,
    input  logic         i_m0_ready,
    output logic [63:0]  o_m0_data,
    output logic         o_m1_valid,
    input  logic         i_m1_ready,
    output logic [63:0]  o_m1_data,
    output logic         o_core_valid,
    input  logic         i_core_ready,
    output logic [63:0]  o_core_data,
    output logic [127:0] o_core_key,
    input  logic         i_core_valid,
    output logic         o_core_ready,
    input  logic [63:0]  i_core_data,
    output logic         o_busy,
    output logic         o_grant,
    output logic         o_timeout
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic          grant_q, grant_d;
    logic [63:0]   data_q, data_d;
    logic [127:0]  key_q, key_d;
    logic [63:0]   m0_data_q, m0_data_d;
    logic [63:0]   m1_data_q, m1_data_d;
    logic [15:0]   timer_q, timer_d;
    logic          timeout_q, timeout_d;
    logic          busy_q, busy_d;
    logic          core_valid_q, core_valid_d;
    logic          core_ready_q, core_ready_d;
    logic          m0_valid_q, m0_valid_d;
    logic          m1_valid_q, m1_valid_d;

    logic          sel_s;
    logic          s_hs_s;
    logic          m_ready_s;
    logic [15:0]   timer_inc_s;
    logic          expire_s;

    // Requester selection: a lone valid wins, a tie goes to the channel not served last.
    always_comb begin
        if (i_s0_valid && i_s1_valid) begin
            sel_s = ~rr_last_q;
        end else if (i_s1_valid) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign o_s0_ready  = i_rst_n & (state_q == ST_IDLE) & i_s0_valid & ~sel_s;
    assign o_s1_ready  = i_rst_n & (state_q == ST_IDLE) & i_s1_valid & sel_s;
    assign s_hs_s      = o_s0_ready | o_s1_ready;
    assign m_ready_s   = grant_q ? i_m1_ready : i_m0_ready;
    assign timer_inc_s = timer_q + 16'd1;
    assign expire_s    = (TIMEOUT_CYCLES != 16'd0) && (timer_inc_s == TIMEOUT_CYCLES);

    // Next-state and datapath updates for the job FSM.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        grant_d   = grant_q;
        data_d    = data_q;
        key_d     = key_q;
        m0_data_d = m0_data_q;
        m1_data_d = m1_data_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_hs_s) begin
                    grant_d = sel_s;
                    data_d  = sel_s ? i_s1_data : i_s0_data;
                    key_d   = sel_s ? i_s1_key : i_s0_key;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i_core_ready) begin
                    timer_d = 16'd0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A result landing in the expiry cycle still wins over the abort.
                if (i_core_valid) begin
                    if (grant_q) begin
                        m1_data_d = i_core_data;
                    end else begin
                        m0_data_d = i_core_data;
                    end
                    state_d = ST_RETURN;
                end else if (expire_s) begin
                    timeout_d = 1'b1;
                    rr_last_d = grant_q;
                    timer_d   = 16'd0;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_inc_s;
                    state_d = ST_WAIT;
                end
            end
            ST_RETURN: begin
                if (m_ready_s) begin
                    rr_last_d = grant_q;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_RETURN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flags are decoded from the next state so they come straight off flops.
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        core_valid_d = (state_d == ST_ISSUE);
        core_ready_d = (state_d == ST_WAIT);
        m0_valid_d   = (state_d == ST_RETURN) && !grant_d;
        m1_valid_d   = (state_d == ST_RETURN) && grant_d;
    end

    // State and datapath registers; rr_last resets to 1 so channel 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            rr_last_q    <= 1'b1;
            grant_q      <= 1'b0;
            data_q       <= 64'd0;
            key_q        <= 128'd0;
            m0_data_q    <= 64'd0;
            m1_data_q    <= 64'd0;
            timer_q      <= 16'd0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            core_valid_q <= 1'b0;
            core_ready_q <= 1'b0;
            m0_valid_q   <= 1'b0;
            m1_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            grant_q      <= grant_d;
            data_q       <= data_d;
            key_q        <= key_d;
            m0_data_q    <= m0_data_d;
            m1_data_q    <= m1_data_d;
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            core_valid_q <= core_valid_d;
            core_ready_q <= core_ready_d;
            m0_valid_q   <= m0_valid_d;
            m1_valid_q   <= m1_valid_d;
        end
    end

    assign o_core_valid = core_valid_q;
    assign o_core_data  = data_q;
    assign o_core_key   = key_q;
    assign o_core_ready = core_ready_q;
    assign o_m0_valid   = m0_valid_q;
    assign o_m0_data    = m0_data_q;
    assign o_m1_valid   = m1_valid_q;
    assign o_m1_data    = m1_data_q;
    assign o_busy       = busy_q;
    assign o_grant      = grant_q;
    assign o_timeout    = timeout_q;
endmodule

// File: tb/tb_tea_arbiter.sv
// Directed bench for tea_arbiter: one instance with the default timeout and
// one with an 8-cycle timeout, driven and sampled on the falling clock edge.
module tb_tea_arbiter;
    localparam logic [63:0]  D0   = 64'h0123456789ABCDEF;
    localparam logic [127:0] K0   = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [63:0]  D1   = 64'hFEDCBA9876543210;
    localparam logic [127:0] K1   = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [63:0]  RES0 = 64'hDEADBEEF00C0FFEE;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    tea_arbiter_if a ();
    tea_arbiter_if b ();

    tea_arbiter dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s0_valid(a.s0_valid), .o_s0_ready(a.s0_ready), .i_s0_data(a.s0_data), .i_s0_key(a.s0_key),
        .i_s1_valid(a.s1_valid), .o_s1_ready(a.s1_ready), .i_s1_data(a.s1_data), .i_s1_key(a.s1_key),
        .o_m0_valid(a.m0_valid), .i_m0_ready(a.m0_ready), .o_m0_data(a.m0_data),
        .o_m1_valid(a.m1_valid), .i_m1_ready(a.m1_ready), .o_m1_data(a.m1_data),
        .o_core_valid(a.core_req_valid), .i_core_ready(a.core_req_ready),
        .o_core_data(a.core_req_data), .o_core_key(a.core_req_key),
        .i_core_valid(a.core_rsp_valid), .o_core_ready(a.core_rsp_ready), .i_core_data(a.core_rsp_data),
        .o_busy(a.busy), .o_grant(a.grant), .o_timeout(a.timeout)
    );

    tea_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut_to (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s0_valid(b.s0_valid), .o_s0_ready(b.s0_ready), .i_s0_data(b.s0_data), .i_s0_key(b.s0_key),
        .i_s1_valid(b.s1_valid), .o_s1_ready(b.s1_ready), .i_s1_data(b.s1_data), .i_s1_key(b.s1_key),
        .o_m0_valid(b.m0_valid), .i_m0_ready(b.m0_ready), .o_m0_data(b.m0_data),
        .o_m1_valid(b.m1_valid), .i_m1_ready(b.m1_ready), .o_m1_data(b.m1_data),
        .o_core_valid(b.core_req_valid), .i_core_ready(b.core_req_ready),
        .o_core_data(b.core_req_data), .o_core_key(b.core_req_key),
        .i_core_valid(b.core_rsp_valid), .o_core_ready(b.core_rsp_ready), .i_core_data(b.core_rsp_data),
        .o_busy(b.busy), .o_grant(b.grant), .o_timeout(b.timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a.s0_valid = 1'b0; a.s0_data = D0; a.s0_key = K0;
        a.s1_valid = 1'b0; a.s1_data = D1; a.s1_key = K1;
        a.m0_ready = 1'b0; a.m1_ready = 1'b0;
        a.core_req_ready = 1'b0; a.core_rsp_valid = 1'b0; a.core_rsp_data = 64'd0;
        b.s0_valid = 1'b0; b.s0_data = D0; b.s0_key = K0;
        b.s1_valid = 1'b0; b.s1_data = D1; b.s1_key = K1;
        b.m0_ready = 1'b0; b.m1_ready = 1'b0;
        b.core_req_ready = 1'b0; b.core_rsp_valid = 1'b0; b.core_rsp_data = 64'd0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One tie job on instance a with both requesters held valid; core answers next cycle.
    task automatic run_tie_job(input logic g, input logic [63:0] res);
        #1;
        chk("tie_s0_ready", a.s0_ready, !g);
        chk("tie_s1_ready", a.s1_ready, g);
        @(negedge clk);
        chk("tie_grant", a.grant, g);
        chk("tie_core_valid", a.core_req_valid, 1'b1);
        chk("tie_core_data", a.core_req_data, g ? D1 : D0);
        chk("tie_core_key", a.core_req_key, g ? K1 : K0);
        chk("tie_no_sready", a.s0_ready | a.s1_ready, 1'b0);
        a.core_req_ready = 1'b1;
        @(negedge clk);
        a.core_req_ready = 1'b0;
        a.core_rsp_valid = 1'b1;
        a.core_rsp_data  = res;
        @(negedge clk);
        a.core_rsp_valid = 1'b0;
        chk("tie_m0_valid", a.m0_valid, !g);
        chk("tie_m1_valid", a.m1_valid, g);
        chk("tie_m_data", g ? a.m1_data : a.m0_data, res);
        a.m0_ready = 1'b1;
        a.m1_ready = 1'b1;
        @(negedge clk);
        a.m0_ready = 1'b0;
        a.m1_ready = 1'b0;
        chk("tie_back_idle", a.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst_busy", a.busy, 1'b0);
        chk("rst_grant", a.grant, 1'b0);
        chk("rst_core_valid", a.core_req_valid, 1'b0);
        chk("rst_core_ready", a.core_rsp_ready, 1'b0);
        chk("rst_core_data", a.core_req_data, 64'd0);
        chk("rst_m_valid", {a.m0_valid, a.m1_valid}, 2'b00);
        chk("rst_m0_data", a.m0_data, 64'd0);
        chk("rst_timeout", b.timeout, 1'b0);
        rst_n = 1'b1;

        // Single job from channel 0 with a 32-cycle core.
        @(negedge clk);
        a.s0_valid = 1'b1;
        #1;
        chk("one_s0_ready", a.s0_ready, 1'b1);
        chk("one_s1_ready", a.s1_ready, 1'b0);
        @(negedge clk);
        a.s0_valid = 1'b0;
        chk("one_core_valid_lat1", a.core_req_valid, 1'b1);
        chk("one_core_data", a.core_req_data, D0);
        chk("one_core_key", a.core_req_key, K0);
        chk("one_grant", a.grant, 1'b0);
        chk("one_busy", a.busy, 1'b1);
        a.core_req_ready = 1'b1;
        @(negedge clk);
        a.core_req_ready = 1'b0;
        chk("one_wait_core_valid", a.core_req_valid, 1'b0);
        chk("one_wait_core_ready", a.core_rsp_ready, 1'b1);
        repeat (31) @(negedge clk);
        chk("one_still_waiting", a.core_rsp_ready, 1'b1);
        a.core_rsp_valid = 1'b1;
        a.core_rsp_data  = RES0;
        @(negedge clk);
        a.core_rsp_valid = 1'b0;
        chk("one_m0_valid", a.m0_valid, 1'b1);
        chk("one_m0_data", a.m0_data, RES0);
        chk("one_m1_valid", a.m1_valid, 1'b0);
        chk("one_core_ready_off", a.core_rsp_ready, 1'b0);
        a.m0_ready = 1'b1;
        @(negedge clk);
        a.m0_ready = 1'b0;
        chk("one_m0_done", a.m0_valid, 1'b0);
        chk("one_idle", a.busy, 1'b0);

        // Contention from reset: grants alternate 0,1,0,1.
        apply_reset();
        a.s0_valid = 1'b1;
        a.s1_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            run_tie_job(j[0], 64'hC0DE000000000000 | 64'(j));
        end
        a.s0_valid = 1'b0;
        a.s1_valid = 1'b0;

        // Backpressure on core accept and on result delivery to channel 1.
        a.s1_valid = 1'b1;
        #1;
        chk("bp_s1_ready", a.s1_ready, 1'b1);
        @(negedge clk);
        a.s1_valid = 1'b0;
        a.s0_valid = 1'b1;
        repeat (5) begin
            #1;
            chk("bp_core_valid_held", a.core_req_valid, 1'b1);
            chk("bp_core_data_held", a.core_req_data, D1);
            chk("bp_core_key_held", a.core_req_key, K1);
            chk("bp_issue_no_s0_ready", a.s0_ready, 1'b0);
            @(negedge clk);
        end
        a.core_req_ready = 1'b1;
        @(negedge clk);
        a.core_req_ready = 1'b0;
        a.core_rsp_valid = 1'b1;
        a.core_rsp_data  = 64'h5A5A5A5AA5A5A5A5;
        @(negedge clk);
        a.core_rsp_valid = 1'b0;
        repeat (7) begin
            #1;
            chk("bp_m1_valid_held", a.m1_valid, 1'b1);
            chk("bp_m1_data_held", a.m1_data, 64'h5A5A5A5AA5A5A5A5);
            chk("bp_m0_valid_low", a.m0_valid, 1'b0);
            chk("bp_ret_no_s0_ready", a.s0_ready, 1'b0);
            @(negedge clk);
        end
        a.m1_ready = 1'b1;
        @(negedge clk);
        a.m1_ready = 1'b0;
        #1;
        chk("bp_m1_done", a.m1_valid, 1'b0);
        chk("bp_idle_s0_ready", a.s0_ready, 1'b1);
        a.s0_valid = 1'b0;
        @(negedge clk);

        // Timeout on the 8-cycle instance, then a result landing in the expiry cycle.
        b.s0_valid = 1'b1;
        @(negedge clk);
        b.s0_valid = 1'b0;
        chk("to_core_valid", b.core_req_valid, 1'b1);
        b.core_req_ready = 1'b1;
        @(negedge clk);
        b.core_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("to_no_early_pulse", b.timeout, 1'b0);
            chk("to_wait_core_ready", b.core_rsp_ready, 1'b1);
            @(negedge clk);
        end
        chk("to_pulse", b.timeout, 1'b1);
        chk("to_idle", b.busy, 1'b0);
        chk("to_no_m_valid", {b.m0_valid, b.m1_valid}, 2'b00);
        b.s0_valid = 1'b1;
        b.s1_valid = 1'b1;
        #1;
        chk("to_next_s1_ready", b.s1_ready, 1'b1);
        chk("to_next_s0_ready", b.s0_ready, 1'b0);
        @(negedge clk);
        b.s0_valid = 1'b0;
        b.s1_valid = 1'b0;
        chk("to_pulse_one_cycle", b.timeout, 1'b0);
        chk("to_next_grant", b.grant, 1'b1);
        b.core_req_ready = 1'b1;
        @(negedge clk);
        b.core_req_ready = 1'b0;
        repeat (7) @(negedge clk);
        b.core_rsp_valid = 1'b1;
        b.core_rsp_data  = 64'h0BADF00D12345678;
        @(negedge clk);
        b.core_rsp_valid = 1'b0;
        chk("tie_expiry_no_pulse", b.timeout, 1'b0);
        chk("tie_expiry_m1_valid", b.m1_valid, 1'b1);
        chk("tie_expiry_m1_data", b.m1_data, 64'h0BADF00D12345678);
        b.m1_ready = 1'b1;
        @(negedge clk);
        b.m1_ready = 1'b0;
        chk("tie_expiry_after_pulse", b.timeout, 1'b0);
        chk("tie_expiry_idle", b.busy, 1'b0);

        // Reset asserted mid-WAIT on a channel-1 job.
        a.s1_valid = 1'b1;
        @(negedge clk);
        a.s1_valid = 1'b0;
        a.core_req_ready = 1'b1;
        @(negedge clk);
        a.core_req_ready = 1'b0;
        @(negedge clk);
        chk("mid_wait_busy", a.busy, 1'b1);
        chk("mid_wait_grant", a.grant, 1'b1);
        a.s0_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", a.busy, 1'b0);
        chk("async_grant", a.grant, 1'b0);
        chk("async_core_ready", a.core_rsp_ready, 1'b0);
        chk("async_core_data", a.core_req_data, 64'd0);
        chk("async_s0_ready", a.s0_ready, 1'b0);
        a.core_rsp_valid = 1'b1;
        a.core_rsp_data  = 64'h1234123412341234;
        repeat (2) @(negedge clk);
        a.core_rsp_valid = 1'b0;
        a.s0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_m", {a.m0_valid, a.m1_valid}, 2'b00);
        chk("post_rst_idle", a.busy, 1'b0);
        a.s0_valid = 1'b1;
        a.s1_valid = 1'b1;
        #1;
        chk("post_rst_tie_s0", a.s0_ready, 1'b1);
        chk("post_rst_tie_s1", a.s1_ready, 1'b0);
        @(negedge clk);
        a.s0_valid = 1'b0;
        a.s1_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
